// File: rtl/hazard_scoreboard_if.sv
// ---------------------------------------------------------------------------
// hazard_scoreboard_if
//
// Groups the decode-stage hazard signals that pass between the pipeline
// (master) and the load-use hazard unit (slave).
//
// Pipeline -> hazard unit
//   ifid_op1, ifid_op2    source registers of the instruction in IF/ID
//   ifid_use1, ifid_use2  the instruction really reads op1 / op2
//   idex_dst              destination register of the instruction in ID/EX
//   idex_read             the ID/EX instruction is a load
//   idex_valid            ID/EX holds a real instruction (0 = bubble)
//   hold                  external freeze of the whole pipeline
//   flush                 IF/ID is being squashed this cycle
// Hazard unit -> pipeline
//   stall                 hold IF/ID and insert a bubble into ID/EX
//   pcdrive               PC write enable
//   haz_src               {op2 caused stall, op1 caused stall}
//   stall_cnt             saturating count of stalled cycles
//
// Handshake: there is no valid/ready pair. idex_valid qualifies every
// idex_* field, and the ifid_use* bits qualify their operand fields.
// Unqualified fields are don't-care. stall is the only back-pressure signal.
// ---------------------------------------------------------------------------
interface hazard_scoreboard_if #(
    parameter int REG_AW = 4,
    parameter int CNT_W  = 16
);
    logic [REG_AW-1:0] ifid_op1;
    logic [REG_AW-1:0] ifid_op2;
    logic              ifid_use1;
    logic              ifid_use2;
    logic [REG_AW-1:0] idex_dst;
    logic              idex_read;
    logic              idex_valid;
    logic              hold;
    logic              flush;
    logic              stall;
    logic              pcdrive;
    logic [1:0]        haz_src;
    logic [CNT_W-1:0]  stall_cnt;

    modport master (
        output ifid_op1, ifid_op2, ifid_use1, ifid_use2,
        output idex_dst, idex_read, idex_valid, hold, flush,
        input  stall, pcdrive, haz_src, stall_cnt
    );

    modport slave (
        input  ifid_op1, ifid_op2, ifid_use1, ifid_use2,
        input  idex_dst, idex_read, idex_valid, hold, flush,
        output stall, pcdrive, haz_src, stall_cnt
    );
endinterface

// File: rtl/hazard_scoreboard.sv
// ---------------------------------------------------------------------------
// hazard_scoreboard
//
// Load-use hazard unit for the decode stage. Each architectural register
// except r0 has a 3-bit countdown that tracks how many more cycles a
// dependent instruction must wait before load data for that register can be
// forwarded. The instruction in IF/ID stalls while either of its used source
// operands matches one of the following:
//   - a load currently in ID/EX, or
//   - a register whose countdown is still nonzero.
//
// Ports
//   clk  rising-edge clock
//   rst  asynchronous, active-high reset; clears the scoreboard and the
//        counter and forces stall low while it is asserted
//   bus  hazard_scoreboard_if.slave (see the interface for field meanings)
//
// Parameters
//   REG_AW    register-address width (2**REG_AW registers)
//   LOAD_LAT  stall cycles a dependent instruction needs behind a load (1..7)
//   CNT_W     width of the saturating stall-cycle counter
// ---------------------------------------------------------------------------
module hazard_scoreboard #(
    parameter int REG_AW   = 4,
    parameter int LOAD_LAT = 1,
    parameter int CNT_W    = 16
) (
    input  logic                clk,
    input  logic                rst,
    hazard_scoreboard_if.slave  bus
);

    localparam int         NumRegs  = 1 << REG_AW;
    // The cycle the load sits in ID/EX is already covered by the direct
    // idex match. The countdown therefore only has to cover the
    // remaining LOAD_LAT-1 cycles.
    localparam logic [2:0] PendInit = 3'(LOAD_LAT - 1);

    // pend[0] is intentionally absent: r0 never hazards.
    logic [2:0]       pend [1:NumRegs-1];
    logic [CNT_W-1:0] stallCnt;

    logic       loadInEx;
    logic       loadCapture;
    logic [2:0] pend1;
    logic [2:0] pend2;
    logic       hz1;
    logic       hz2;
    logic       stallInt;

    assign loadInEx    = bus.idex_valid & bus.idex_read;
    assign loadCapture = loadInEx & ~bus.hold & (bus.idex_dst != '0);

    // Scoreboard lookup for both operands. Address 0 falls through to 0.
    always_comb begin
        pend1 = '0;
        pend2 = '0;
        for (int r = 1; r < NumRegs; r++) begin
            if (bus.ifid_op1 == REG_AW'(r)) pend1 = pend[r];
            if (bus.ifid_op2 == REG_AW'(r)) pend2 = pend[r];
        end
    end

    // Each operand is evaluated on its own. A zero or unused other operand
    // never masks a hazard.
    always_comb begin
        hz1 = bus.ifid_use1 & (bus.ifid_op1 != '0) &
              ((pend1 != '0) | (loadInEx & (bus.idex_dst == bus.ifid_op1)));
        hz2 = bus.ifid_use2 & (bus.ifid_op2 != '0) &
              ((pend2 != '0) | (loadInEx & (bus.idex_dst == bus.ifid_op2)));
    end

    // rst gates stall combinationally. Asserting reset mid-stall therefore
    // releases the pipeline immediately, without waiting for a clock edge.
    assign stallInt      = (hz1 | hz2) & ~bus.flush & ~rst;
    assign bus.stall     = stallInt;
    assign bus.pcdrive   = ~stallInt & ~bus.hold;
    assign bus.haz_src   = stallInt ? {hz2, hz1} : 2'b00;
    assign bus.stall_cnt = stallCnt;

    // hold freezes every piece of state, including while a stall is shown.
    // A fresh load to a register overrides that register's running count.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int r = 1; r < NumRegs; r++) pend[r] <= '0;
            stallCnt <= '0;
        end else if (!bus.hold) begin
            for (int r = 1; r < NumRegs; r++) begin
                if (loadCapture && (bus.idex_dst == REG_AW'(r))) begin
                    pend[r] <= PendInit;
                end else if (pend[r] != '0) begin
                    pend[r] <= pend[r] - 3'd1;
                end
            end
            if (stallInt && (stallCnt != {CNT_W{1'b1}})) begin
                stallCnt <= stallCnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// ---------------------------------------------------------------------------
// tb_hazard_scoreboard
//
// Three hazard units share one stimulus set:
//   dutA  LOAD_LAT=1, CNT_W=16  (legacy single-stall behaviour)
//   dutB  LOAD_LAT=3, CNT_W=16
//   dutC  LOAD_LAT=3, CNT_W=2   (counter saturation)
// Inputs change 1ns after a rising edge. Outputs are checked 1ns after that.
// ---------------------------------------------------------------------------
module tb_hazard_scoreboard;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    // ---------------- shared stimulus ----------------
    logic [3:0] op1, op2, dst;
    logic       use1, use2, rd, vld, hold, flush;

    hazard_scoreboard_if #(.REG_AW(4), .CNT_W(16)) busA ();
    hazard_scoreboard_if #(.REG_AW(4), .CNT_W(16)) busB ();
    hazard_scoreboard_if #(.REG_AW(4), .CNT_W(2))  busC ();

    assign busA.ifid_op1 = op1;  assign busA.ifid_op2 = op2;  assign busA.ifid_use1 = use1;
    assign busA.ifid_use2 = use2; assign busA.idex_dst = dst; assign busA.idex_read = rd;
    assign busA.idex_valid = vld; assign busA.hold = hold;    assign busA.flush = flush;

    assign busB.ifid_op1 = op1;  assign busB.ifid_op2 = op2;  assign busB.ifid_use1 = use1;
    assign busB.ifid_use2 = use2; assign busB.idex_dst = dst; assign busB.idex_read = rd;
    assign busB.idex_valid = vld; assign busB.hold = hold;    assign busB.flush = flush;

    assign busC.ifid_op1 = op1;  assign busC.ifid_op2 = op2;  assign busC.ifid_use1 = use1;
    assign busC.ifid_use2 = use2; assign busC.idex_dst = dst; assign busC.idex_read = rd;
    assign busC.idex_valid = vld; assign busC.hold = hold;    assign busC.flush = flush;

    hazard_scoreboard #(.REG_AW(4), .LOAD_LAT(1), .CNT_W(16)) dutA (.clk(clk), .rst(rst), .bus(busA.slave));
    hazard_scoreboard #(.REG_AW(4), .LOAD_LAT(3), .CNT_W(16)) dutB (.clk(clk), .rst(rst), .bus(busB.slave));
    hazard_scoreboard #(.REG_AW(4), .LOAD_LAT(3), .CNT_W(2))  dutC (.clk(clk), .rst(rst), .bus(busC.slave));

    // ---------------- scoreboard / checker ----------------
    int numChecks = 0;
    int numErrors = 0;

    task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
        numChecks++;
        if (got !== exp) begin
            numErrors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clearIn();
        op1 = '0; op2 = '0; dst = '0;
        use1 = 0; use2 = 0; rd = 0; vld = 0; hold = 0; flush = 0;
    endtask

    task automatic doReset();
        rst = 1'b1;
        clearIn();
        tick();
        rst = 1'b0;
        #1;
    endtask

    // Load to dst in ID/EX
    task automatic loadInEx(input logic [3:0] d);
        vld = 1; rd = 1; dst = d;
    endtask

    task automatic bubble();
        vld = 0; rd = 0; dst = '0;
    endtask

    // Watchdog: the bench is purely clock-counted, but never let it hang.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    // ---------------- stimulus ----------------
    initial begin
        clearIn();
        // Reset held with a live hazard pattern: stall must stay low.
        loadInEx(4'd3); op1 = 4'd3; use1 = 1;
        #2;
        checkVal("rst_stall", busB.stall, 1'b0);
        checkVal("rst_hazsrc", busB.haz_src, 2'b00);
        checkVal("rst_pcdrive", busB.pcdrive, 1'b1);
        checkVal("rst_cnt", busB.stall_cnt, 16'd0);
        hold = 1;
        #1;
        checkVal("rst_pcdrive_hold", busB.pcdrive, 1'b0);
        doReset();

        // --- LOAD_LAT=1: single stall on op1 ---
        loadInEx(4'd3); op1 = 4'd3; use1 = 1;
        #1;
        checkVal("l1_stall", busA.stall, 1'b1);
        checkVal("l1_hazsrc", busA.haz_src, 2'b01);
        checkVal("l1_pcdrive0", busA.pcdrive, 1'b0);
        tick(); bubble(); #1;
        checkVal("l1_release", busA.stall, 1'b0);
        checkVal("l1_pcdrive1", busA.pcdrive, 1'b1);
        checkVal("l1_cnt", busA.stall_cnt, 16'd1);
        doReset();

        // --- LOAD_LAT=3: three stalls on op2 ---
        loadInEx(4'd5); op2 = 4'd5; use2 = 1;
        for (int i = 0; i < 3; i++) begin
            #1;
            checkVal($sformatf("l3_stall%0d", i), busB.stall, 1'b1);
            checkVal($sformatf("l3_hazsrc%0d", i), busB.haz_src, 2'b10);
            tick(); bubble();
        end
        #1;
        checkVal("l3_release", busB.stall, 1'b0);
        checkVal("l3_cnt", busB.stall_cnt, 16'd3);
        doReset();

        // --- LOAD_LAT=3 with a 4-cycle hold after two stall cycles ---
        loadInEx(4'd5); op2 = 4'd5; use2 = 1;
        tick(); bubble();
        tick();
        hold = 1;
        for (int i = 0; i < 4; i++) begin
            #1;
            checkVal($sformatf("hold_stall%0d", i), busB.stall, 1'b1);
            checkVal($sformatf("hold_pc%0d", i), busB.pcdrive, 1'b0);
            checkVal($sformatf("hold_cnt%0d", i), busB.stall_cnt, 16'd2);
            tick();
        end
        hold = 0;
        #1;
        checkVal("hold_last_stall", busB.stall, 1'b1);
        tick();
        checkVal("hold_release", busB.stall, 1'b0);
        checkVal("hold_cnt_final", busB.stall_cnt, 16'd3);
        doReset();

        // --- register 0 and unused operands never hazard ---
        loadInEx(4'd0); op1 = 4'd0; use1 = 1;
        #1;
        checkVal("r0_load", busB.stall, 1'b0);
        loadInEx(4'd4); op1 = 4'd4; use1 = 0;
        #1;
        checkVal("unused_op1", busB.stall, 1'b0);
        loadInEx(4'd2); op1 = 4'd0; use1 = 1; op2 = 4'd2; use2 = 1;
        #1;
        checkVal("op2_nomask", busB.stall, 1'b1);
        checkVal("op2_nomask_src", busB.haz_src, 2'b10);
        doReset();

        // --- flush mid-stall, then re-issue of the dependent instruction ---
        loadInEx(4'd7); op1 = 4'd7; use1 = 1;
        #1;
        checkVal("fl_stall0", busB.stall, 1'b1);
        tick(); bubble();
        flush = 1;
        #1;
        checkVal("fl_forced", busB.stall, 1'b0);
        checkVal("fl_hazsrc", busB.haz_src, 2'b00);
        checkVal("fl_pcdrive", busB.pcdrive, 1'b1);
        tick();
        flush = 0;
        #1;
        checkVal("fl_remain", busB.stall, 1'b1);
        tick();
        checkVal("fl_done", busB.stall, 1'b0);
        checkVal("fl_cnt", busB.stall_cnt, 16'd2);
        doReset();

        // --- CNT_W=2 saturation, then reset mid-stall ---
        loadInEx(4'd6); op1 = 4'd6; use1 = 1;
        for (int i = 0; i < 5; i++) tick();
        checkVal("sat_cnt", busC.stall_cnt, 2'd3);
        checkVal("sat_stall", busC.stall, 1'b1);
        rst = 1;
        #1;
        checkVal("midrst_stall", busC.stall, 1'b0);
        checkVal("midrst_cnt", busC.stall_cnt, 2'd0);
        checkVal("midrst_pcdrive", busC.pcdrive, 1'b1);
        bubble();
        tick();
        rst = 0;
        #1;
        checkVal("postrst_nostall", busC.stall, 1'b0);
        checkVal("postrst_nostallB", busB.stall, 1'b0);
        tick();
        checkVal("postrst_cnt", busC.stall_cnt, 2'd0);

        $display("Simulation finished: %0d checks, %0d errors", numChecks, numErrors);
        $finish;
    end

endmodule

// File: doc/hazard_scoreboard.md
Name: hazard_scoreboard

Overview:
Parametrised load-use hazard unit for the decode stage. It is the successor to the single-cycle load-use interlock. A per-register countdown scoreboard tracks loads whose data is not yet forwardable, so the pipeline can stall for a configurable load latency instead of a fixed single cycle. It also provides external freeze, flush override, per-operand stall reasons and a saturating stall-cycle counter. It sits between the IF/ID and ID/EX pipeline registers and drives PC write-enable, IF/ID hold and ID/EX bubble insertion.

Parameters:
REG_AW, 4, register-address width; register file has 2**REG_AW entries.
LOAD_LAT, 1, stall cycles a dependent instruction needs behind a load; legal range 1..7. LOAD_LAT=1 reproduces the legacy single-stall interlock.
CNT_W, 16, width of the stall-cycle counter.

Ports:
clk  in  1  system clock, rising edge.
rst  in  1  asynchronous, active-high reset.
ifid_op1  in  REG_AW  source register 1 of the instruction in IF/ID.
ifid_op2  in  REG_AW  source register 2 of the instruction in IF/ID.
ifid_use1  in  1  instruction in IF/ID actually reads op1.
ifid_use2  in  1  instruction in IF/ID actually reads op2.
idex_dst  in  REG_AW  destination register of the instruction in ID/EX.
idex_read  in  1  instruction in ID/EX is a load.
idex_valid  in  1  ID/EX holds a real instruction, not a bubble.
hold  in  1  external pipeline freeze, e.g. memory wait.
flush  in  1  IF/ID contents are being squashed this cycle.
stall  out  1  hold IF/ID and insert a bubble into ID/EX.
pcdrive  out  1  PC write enable; equals ~stall & ~hold.
haz_src  out  2  bit0: op1 caused the stall; bit1: op2 caused the stall.
stall_cnt  out  CNT_W  saturating count of stalled cycles.

Behaviour:
- Scoreboard: one 3-bit countdown pend[r] for each r in 1..2**REG_AW-1. pend[0] does not exist and always reads 0.
- Load capture: a load is captured on a clock edge when idex_valid & idex_read & ~hold & idex_dst!=0.
  - Captured load loads pend[idex_dst] <= LOAD_LAT-1. This overrides any count still running for that register.
- Decrement: on every edge with ~hold, every other nonzero pend[r] decrements by 1.
- hold=1 freezes all pend[] and stall_cnt.
- Operand hazard: hz1 = ifid_use1 & ifid_op1!=0 & (pend[op1]!=0 | (idex_valid & idex_read & idex_dst==op1)). hz2 is the same for op2.
  - Register 0 never hazards.
  - Each operand is checked independently; a zero in the other operand does not mask a hazard.
- Combinational outputs:
  - stall = (hz1|hz2) & ~flush & ~rst.
  - haz_src = {hz2,hz1} when stall=1, else 00.
  - pcdrive = ~stall & ~hold.
  - While rst is asserted: stall=0, haz_src=00, pcdrive=~hold.
- Stall timing: a dependent instruction arriving in IF/ID while its producer load is in ID/EX stalls exactly LOAD_LAT cycles (hold cycles excluded), then proceeds.
  - The ID/EX bubbles created by the stall have idex_valid=0, so they never re-arm the scoreboard.
- Flush:
  - Forces stall=0 that cycle.
  - Does not clear pend[]; loads already in flight still complete.
- stall_cnt:
  - Increments on each edge where stall=1 & ~hold.
  - Saturates at 2**CNT_W-1.
- Reset:
  - Asynchronously clears all pend[] and stall_cnt to 0.
  - Reset mid-stall releases the stall immediately.
- Simultaneous events:
  - Load to r captured on the same edge that pend[r] would decrement: the load value wins.
  - Stall and hold both active: stall is asserted and no state advances.

Test Plan:
- LOAD_LAT=1; load r3 in ID/EX; IF/ID reads op1=r3, use1=1 -> stall=1 and haz_src=01 for exactly 1 cycle; pcdrive=0 then 1; stall_cnt=1.
- LOAD_LAT=3; load r5, then dependent on op2=r5 -> stall for 3 consecutive cycles, haz_src=10; 4th cycle stall=0; stall_cnt=3.
- LOAD_LAT=3; load r5; 2 stall cycles elapse; hold=1 for 4 cycles -> stall stays 1 and pend[r5] frozen; after hold drops, exactly 1 more stall cycle; stall_cnt=3.
- Load to r0, or op1=r0 with use1=1, or a matching load with use1=0 -> stall never asserts. Also op1=r0 with op2=matching load r2 and use2=1 -> stall=1 with haz_src=10.
- LOAD_LAT=3; dependent stalled on r7; assert flush -> stall=0 that cycle. A new dependent on r7 next cycle -> stall for the remaining pend count only.
- CNT_W=2; force 5 stall cycles -> stall_cnt saturates at 3. Assert rst mid-stall -> stall=0, stall_cnt=0, all pend cleared, so the next dependent instruction does not stall.
